mem_stage: RTL and testbench
============================

# mem_stage

- MEM pipeline stage, between the EX/MEM register and the MEM/WB register.
- Consumes the EX/MEM outputs: ALU op, effective address, store data, destination register, write flag and ALU result.
- Performs loads and stores over a request/acknowledge data bus, handling byte-lane alignment and sign extension. Raises a stall request to the pipeline controller until the access completes.
- Passes non-memory instructions through combinationally.

## Interface
Parameters:
- MAX_WAIT, 255: cycles in BUSY without dbus_ack before the watchdog aborts the access (8-bit counter; 0 disables the watchdog).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-low
- stall  input  6  pipeline stall vector; stall[4] set means the MEM stage is held
- mem_aluop  input  5  operation from EX/MEM
- mem_mem_addr  input  32  effective byte address
- mem_reg2  input  32  store source data
- mem_wd  input  5  destination register
- mem_wreg  input  1  register write enable
- mem_wdata  input  32  ALU result
- wb_wd  output  5  destination register to MEM/WB
- wb_wreg  output  1  write enable to MEM/WB
- wb_wdata  output  32  write-back data to MEM/WB
- stallreq_mem  output  1  stall request to the pipeline controller
- dbus_req  output  1  bus request, held until acknowledged
- dbus_we  output  1  1 = store
- dbus_addr  output  32  word address, {mem_mem_addr[31:2], 2'b00}
- dbus_be  output  4  byte enables
- dbus_wdata  output  32  lane-replicated store data
- dbus_ack  input  1  one-cycle completion strobe from the bus
- dbus_rdata  input  32  read data, valid when dbus_ack is 1
- bus_err  output  1  one-cycle pulse on watchdog abort
- misalign  output  1  misaligned-access pulse (exists only with MEM_MISALIGN_TRAP_EN)

## Operation
- Op codes:
  - Loads: LB=5'h10, LH=5'h11, LW=5'h12, LBU=5'h13, LHU=5'h14.
  - Stores: SB=5'h15, SH=5'h16, SW=5'h17.
  - Any other code is a non-memory op.
- FSM states IDLE, BUSY, DONE; reset state IDLE.
- IDLE:
  - Memory op present → stallreq_mem=1 (combinational), next state BUSY, watchdog counter cleared.
  - Non-memory op → wb_* = mem_wd/mem_wreg/mem_wdata.
- BUSY:
  - dbus_req=1; dbus_we, dbus_addr, dbus_be and dbus_wdata are held stable; stallreq_mem=1.
  - dbus_ack=1 → latch the extended load data, next state DONE.
  - Counter reaches MAX_WAIT → bus_err=1 for one cycle, load data forced to 0, next state DONE.
- DONE:
  - stallreq_mem=0, dbus_req=0.
  - Load: wb_wreg=mem_wreg, wb_wdata=latched load data.
  - Store: wb_wreg=0.
  - stall[4]=0 → IDLE; stall[4]=1 → stay in DONE holding outputs.
- wb_wreg=0 in IDLE-with-memory-op and in BUSY.
- Byte enables and store data:
  - SB: dbus_be=4'b0001<<addr[1:0], dbus_wdata={4{reg2[7:0]}}.
  - SH: dbus_be=addr[1]?4'b1100:4'b0011, dbus_wdata={2{reg2[15:0]}}.
  - SW: dbus_be=4'b1111, dbus_wdata=reg2.
  - Loads: dbus_be=4'b1111.
- Load extraction:
  - LB/LBU take byte addr[1:0]; LH/LHU take halfword addr[1].
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
- Reset (rst=0) in any state: next state IDLE, counter cleared. All outputs read 0 while rst=0, including dbus_req (the access is abandoned).

## Timing
- Zero-wait bus (ack in the first BUSY cycle): memory op occupies MEM for 3 cycles — IDLE (stall), BUSY (req+ack), DONE (result).
- k-cycle bus: 2+k cycles.
- dbus_req rises the cycle after the op appears; it never asserts in the same cycle the op arrives.
- dbus_req drops in the cycle after dbus_ack.
- dbus_ack outside BUSY is ignored.
- Watchdog: bus_err asserts in BUSY cycle MAX_WAIT+1 if no ack.
- Ack and watchdog expiry in the same cycle: the ack wins, no bus_err.
- Outputs after reset: every output 0 and FSM in IDLE in the first cycle after rst returns to 1.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0: no bus access, FSM stays in IDLE, stallreq_mem=0, wb_wreg=0, misalign=1 for that cycle.
  - misalign resets to 0.
- Undefined:
  - No misalign port.
  - Misaligned halfword accesses ignore addr[0]; misaligned word accesses ignore addr[1:0].
  - The access proceeds normally.

## Test plan
- LW addr=0x100, ack after 1 BUSY cycle, rdata=0xDEADBEEF → stallreq high 2 cycles, wb_wdata=0xDEADBEEF, wb_wreg=1 in DONE.
- LB addr=0x103, rdata=0x80AABBCC → wb_wdata=0xFFFFFF80.
- LBU addr=0x103, rdata=0x80AABBCC → wb_wdata=0x00000080.
- SH addr=0x202, reg2=0x1234ABCD → dbus_be=4'b1100, dbus_wdata=0xABCDABCD, dbus_we=1, wb_wreg=0.
- MAX_WAIT=4, no ack → bus_err pulses in the 5th BUSY cycle; DONE load data=0; dbus_req then drops.
- rst=0 during the 2nd BUSY cycle → dbus_req=0 next cycle, FSM IDLE, all outputs 0.
- With MEM_MISALIGN_TRAP_EN, LW addr=0x101 → misalign=1, dbus_req never rises, stallreq_mem=0.
- stall[4]=1 held 3 cycles in DONE → load data stable for all 3 cycles; IDLE after stall[4]=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store over a req/ack data bus with lane alignment and a watchdog.
// Optional build macro MEM_MISALIGN_TRAP_EN adds the misalign trap output.
//
// state | meaning
// IDLE  | pass-through, or accept a memory op and latch its bus fields
// BUSY  | bus request held until ack or watchdog expiry
// DONE  | present load result to MEM/WB until the stage is released
module mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq_mem,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [4:0] OP_LB  = 5'h10;
  localparam logic [4:0] OP_LH  = 5'h11;
  localparam logic [4:0] OP_LW  = 5'h12;
  localparam logic [4:0] OP_LBU = 5'h13;
  localparam logic [4:0] OP_LHU = 5'h14;
  localparam logic [4:0] OP_SB  = 5'h15;
  localparam logic [4:0] OP_SH  = 5'h16;
  localparam logic [4:0] OP_SW  = 5'h17;

  localparam logic [7:0] WAIT_INIT = 8'(MAX_WAIT);
  localparam bit         WD_EN     = (MAX_WAIT != 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [4:0]  op_q;
  logic [1:0]  lo_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;

  logic        is_load, is_store, is_mem, trap;
  logic        launch, timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  function automatic logic op_is_load(input logic [4:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic [31:0] extract(input logic [4:0] op, input logic [1:0] lo,
                                          input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {lo, 3'b000});
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  assign is_load  = op_is_load(mem_aluop);
  assign is_store = (mem_aluop >= OP_SB) && (mem_aluop <= OP_SW);
  assign is_mem   = is_load || is_store;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (((mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH))
                 && mem_mem_addr[0])
             || (((mem_aluop == OP_LW) || (mem_aluop == OP_SW)) && (mem_mem_addr[1:0] != 2'b00));
  assign misalign = rst && (state_q == IDLE) && is_mem && trap;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = mem_reg2;
    case (mem_aluop)
      OP_SB: begin
        be_c    = 4'b0001 << mem_mem_addr[1:0];
        wdata_c = {4{mem_reg2[7:0]}};
      end
      OP_SH: begin
        be_c    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    launch       = 1'b0;
    timeout      = 1'b0;
    wb_wd        = mem_wd;
    wb_wreg      = 1'b0;
    wb_wdata     = '0;
    stallreq_mem = 1'b0;
    dbus_req     = 1'b0;
    dbus_we      = 1'b0;
    dbus_addr    = '0;
    dbus_be      = '0;
    dbus_wdata   = '0;
    bus_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_mem) begin
          wb_wreg  = mem_wreg;
          wb_wdata = mem_wdata;
        end else if (!trap) begin
          stallreq_mem = 1'b1;
          wb_wdata     = mem_wdata;
          launch       = 1'b1;
          wait_d       = WAIT_INIT;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        dbus_req     = 1'b1;
        dbus_we      = we_q;
        dbus_addr    = addr_q;
        dbus_be      = be_q;
        dbus_wdata   = wdata_q;
        stallreq_mem = 1'b1;
        if (dbus_ack) begin
          state_d = DONE;
        end else if (WD_EN && (wait_q == 8'd0)) begin
          timeout = 1'b1;
          bus_err = 1'b1;
          state_d = DONE;
        end else if (WD_EN) begin
          wait_d = wait_q - 8'd1;
        end
      end
      DONE: begin
        if (op_is_load(op_q)) begin
          wb_wreg  = mem_wreg;
          wb_wdata = load_q;
        end
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs read zero for as long as reset is held, abandoning any access.
    if (!rst) begin
      wb_wd        = '0;
      wb_wreg      = 1'b0;
      wb_wdata     = '0;
      stallreq_mem = 1'b0;
      dbus_req     = 1'b0;
      dbus_we      = 1'b0;
      dbus_addr    = '0;
      dbus_be      = '0;
      dbus_wdata   = '0;
      bus_err      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      op_q    <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (launch) begin
        op_q    <= mem_aluop;
        lo_q    <= mem_mem_addr[1:0];
        we_q    <= is_store;
        addr_q  <= {mem_mem_addr[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wdata_c;
      end
      if (state_q == BUSY && dbus_ack) load_q <= extract(op_q, lo_q, dbus_rdata);
      else if (timeout) load_q <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (watchdog shortened to MAX_WAIT=4).
// Build with MEM_MISALIGN_TRAP_EN defined to exercise the misalign trap instead of pass-through.
module tb_mem_stage;

  localparam logic [4:0] NOP = 5'h00, LB = 5'h10, LH = 5'h11, LW = 5'h12, LBU = 5'h13,
                         LHU = 5'h14, SB = 5'h15, SH = 5'h16;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2, mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq_mem, dbus_req, dbus_we, dbus_ack, bus_err;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stallreq_mem(stallreq_mem),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .bus_err(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  task automatic next_cyc;
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = '0;
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] r2);
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = '0;
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = r2;
    mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h1111_1111;
    #1;
  endtask

  task automatic retire;
    @(posedge clk); #1;
    dbus_ack = 1'b0; dbus_rdata = '0;
    mem_aluop = NOP; mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'hA5A5_0000;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    mem_aluop = NOP; mem_mem_addr = '0; mem_reg2 = '0;
    mem_wd = 5'h1F; mem_wreg = 1'b1; mem_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({wb_wd, wb_wreg, wb_wdata} !== '0) $display("FAIL rst_held_wb act=%h exp=0", {wb_wd, wb_wreg, wb_wdata}); else passed++;
    @(posedge clk); #1;
    rst = 1'b1; mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
    #1;
    total++; if ({wb_wd, wb_wreg, wb_wdata, stallreq_mem, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, bus_err} !== '0)
      $display("FAIL rst_release_outputs wb=%h req=%b stall=%b err=%b exp all 0", wb_wdata, dbus_req, stallreq_mem, bus_err);
    else passed++;
  endtask

  task automatic test_lw;
    issue(LW, 32'h100, '0);
    total++; if ({stallreq_mem, dbus_req, wb_wreg} !== 3'b100) $display("FAIL lw_idle stall/req/wreg act=%b exp=100", {stallreq_mem, dbus_req, wb_wreg}); else passed++;
    next_cyc; dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF; #1;
    total++; if ({stallreq_mem, dbus_req, dbus_we, dbus_be} !== 7'b1101111) $display("FAIL lw_busy stall/req/we/be act=%b exp=1101111", {stallreq_mem, dbus_req, dbus_we, dbus_be}); else passed++;
    total++; if (dbus_addr !== 32'h100) $display("FAIL lw_addr act=%h exp=00000100", dbus_addr); else passed++;
    next_cyc;
    total++; if ({stallreq_mem, dbus_req} !== 2'b00) $display("FAIL lw_done stall/req act=%b exp=00", {stallreq_mem, dbus_req}); else passed++;
    total++; if (wb_wdata !== 32'hDEAD_BEEF || wb_wreg !== 1'b1 || wb_wd !== 5'd7)
      $display("FAIL lw_done_wb act=%h/%b/%0d exp=deadbeef/1/7", wb_wdata, wb_wreg, wb_wd);
    else passed++;
    retire;
    total++; if (wb_wdata !== 32'hA5A5_0000 || wb_wreg !== 1'b1 || wb_wd !== 5'd3 || stallreq_mem !== 1'b0)
      $display("FAIL lw_idle_passthru act=%h/%b/%0d exp=a5a50000/1/3", wb_wdata, wb_wreg, wb_wd);
    else passed++;
  endtask

  task automatic test_load_ext(input logic [4:0] op, input logic [31:0] addr,
                               input logic [31:0] rd, input logic [31:0] exp, input string name);
    issue(op, addr, '0);
    next_cyc; dbus_ack = 1'b1; dbus_rdata = rd; #1;
    next_cyc;
    total++; if (wb_wdata !== exp) $display("FAIL %s act=%h exp=%h", name, wb_wdata, exp); else passed++;
    retire;
  endtask

  task automatic test_store;
    issue(SH, 32'h202, 32'h1234_ABCD);
    dbus_ack = 1'b1; #1;
    next_cyc;
    total++; if ({dbus_req, dbus_we, dbus_be, wb_wreg} !== 7'b1111000) $display("FAIL sh_busy req/we/be/wreg act=%b exp=1111000", {dbus_req, dbus_we, dbus_be, wb_wreg}); else passed++;
    total++; if (dbus_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata act=%h exp=abcdabcd", dbus_wdata); else passed++;
    mem_mem_addr = 32'h0; mem_reg2 = 32'h0;
    next_cyc; dbus_ack = 1'b1; #1;
    total++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h200 || dbus_wdata !== 32'hABCD_ABCD || dbus_be !== 4'b1100)
      $display("FAIL sh_held act=%b/%h/%h/%b exp=1/00000200/abcdabcd/1100", dbus_req, dbus_addr, dbus_wdata, dbus_be);
    else passed++;
    next_cyc;
    total++; if ({dbus_req, wb_wreg, stallreq_mem} !== 3'b000) $display("FAIL sh_done req/wreg/stall act=%b exp=000", {dbus_req, wb_wreg, stallreq_mem}); else passed++;
    retire;
    issue(SB, 32'h201, 32'h0000_00CD);
    next_cyc;
    total++; if (dbus_be !== 4'b0010 || dbus_wdata !== 32'hCDCD_CDCD)
      $display("FAIL sb_lane act=%b/%h exp=0010/cdcdcdcd", dbus_be, dbus_wdata);
    else passed++;
    dbus_ack = 1'b1; #1;
    next_cyc;
    retire;
  endtask

  task automatic test_watchdog;
    issue(LW, 32'h300, '0);
    for (int i = 1; i <= 5; i++) begin
      next_cyc;
      total++; if (bus_err !== (i == 5) || dbus_req !== 1'b1)
        $display("FAIL wd_busy%0d err/req act=%b/%b exp=%b/1", i, bus_err, dbus_req, (i == 5));
      else passed++;
    end
    next_cyc;
    total++; if ({bus_err, dbus_req, stallreq_mem} !== 3'b000 || wb_wdata !== 32'h0 || wb_wreg !== 1'b1)
      $display("FAIL wd_done err/req/stall=%b wb=%h/%b exp=000 0/1", {bus_err, dbus_req, stallreq_mem}, wb_wdata, wb_wreg);
    else passed++;
    retire;
    issue(LW, 32'h304, '0);
    for (int i = 1; i <= 4; i++) next_cyc;
    next_cyc; dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D; #1;
    total++; if (bus_err !== 1'b0) $display("FAIL wd_ack_wins err act=%b exp=0", bus_err); else passed++;
    next_cyc;
    total++; if (wb_wdata !== 32'hCAFE_F00D) $display("FAIL wd_ack_wins_data act=%h exp=cafef00d", wb_wdata); else passed++;
    retire;
  endtask

  task automatic test_reset_busy;
    issue(LW, 32'h100, '0);
    next_cyc;
    next_cyc;
    rst = 1'b0; #1;
    total++; if ({dbus_req, stallreq_mem} !== 2'b00) $display("FAIL rstbusy_held req/stall act=%b exp=00", {dbus_req, stallreq_mem}); else passed++;
    @(posedge clk); #1;
    rst = 1'b1; mem_aluop = NOP; mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;
    #1;
    total++; if ({wb_wd, wb_wreg, wb_wdata, stallreq_mem, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, bus_err} !== '0)
      $display("FAIL rstbusy_outputs req=%b stall=%b wb=%h exp all 0", dbus_req, stallreq_mem, wb_wdata);
    else passed++;
    issue(LW, 32'h104, '0);
    total++; if ({stallreq_mem, dbus_req} !== 2'b10) $display("FAIL rstbusy_idle stall/req act=%b exp=10", {stallreq_mem, dbus_req}); else passed++;
    next_cyc; dbus_ack = 1'b1; dbus_rdata = 32'h0000_0001; #1;
    next_cyc;
    retire;
  endtask

  task automatic test_stall_hold;
    issue(LW, 32'h108, '0);
    next_cyc;
    next_cyc; dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678; #1;
    next_cyc; stall = 6'b010000; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (wb_wdata !== 32'h1234_5678 || wb_wreg !== 1'b1 || stallreq_mem !== 1'b0 || dbus_req !== 1'b0)
        $display("FAIL stall_hold%0d wb=%h wreg=%b stall=%b req=%b exp=12345678/1/0/0", i, wb_wdata, wb_wreg, stallreq_mem, dbus_req);
      else passed++;
      if (i < 2) next_cyc;
    end
    stall = '0;
    retire;
    total++; if (wb_wdata !== 32'hA5A5_0000 || stallreq_mem !== 1'b0) $display("FAIL stall_release act=%h exp=a5a50000", wb_wdata); else passed++;
  endtask

  task automatic test_misalign;
    issue(LW, 32'h101, '0);
`ifdef MEM_MISALIGN_TRAP_EN
    total++; if ({misalign, stallreq_mem, wb_wreg, dbus_req} !== 4'b1000)
      $display("FAIL mis_trap mis/stall/wreg/req act=%b exp=1000", {misalign, stallreq_mem, wb_wreg, dbus_req});
    else passed++;
    retire;
    total++; if ({misalign, dbus_req} !== 2'b00) $display("FAIL mis_after mis/req act=%b exp=00", {misalign, dbus_req}); else passed++;
`else
    total++; if (stallreq_mem !== 1'b1) $display("FAIL mis_proceed stall act=%b exp=1", stallreq_mem); else passed++;
    next_cyc; dbus_ack = 1'b1; dbus_rdata = 32'h0BAD_F00D; #1;
    total++; if (dbus_addr !== 32'h100 || dbus_be !== 4'b1111) $display("FAIL mis_addr act=%h/%b exp=00000100/1111", dbus_addr, dbus_be); else passed++;
    next_cyc;
    total++; if (wb_wdata !== 32'h0BAD_F00D) $display("FAIL mis_data act=%h exp=0badf00d", wb_wdata); else passed++;
    retire;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_lw;
    test_load_ext(LB,  32'h103, 32'h80AA_BBCC, 32'hFFFF_FF80, "lb_sext");
    test_load_ext(LBU, 32'h103, 32'h80AA_BBCC, 32'h0000_0080, "lbu_zext");
    test_load_ext(LH,  32'h102, 32'h80AA_BBCC, 32'hFFFF_80AA, "lh_sext");
    test_load_ext(LHU, 32'h100, 32'h80AA_BBCC, 32'h0000_BBCC, "lhu_zext");
    test_watchdog;
    test_store;
    test_reset_busy;
    test_stall_hold;
    test_misalign;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
